// File: rtl/alu_result_buffer.sv
// alu_result_buffer: ALU result FIFO with a valid/ready handshake and a running arithmetic sum
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_data,
  input  logic [1:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_data,
  output logic [1:0]                 out_op,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       acc_clr,
  output logic [ACC_W-1:0]           acc,
  output logic                       acc_ovf
);
  localparam int AW = $clog2(DEPTH);
  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          push, pop;
  logic [ACC_W:0] sum;
  assign in_ready  = (count != (AW+1)'(DEPTH)) && !rst;
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {out_op, out_data} = mem[rp];
  assign sum = {1'b0, acc} + (ACC_W+1)'(in_data);
  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      acc     <= '0;
      acc_ovf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= {in_op, in_data};
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      // clear wins over a same-cycle accumulate; the push itself is unaffected
      if (acc_clr) begin
        acc     <= '0;
        acc_ovf <= 1'b0;
      end else if (push && in_op[1]) begin
        acc     <= sum[ACC_W-1:0];
        acc_ovf <= acc_ovf | sum[ACC_W];
      end
    end
  end
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed table vectors plus wrap, overflow and reset sequences
module tb_alu_result_buffer;
  logic clk = 0, rst, in_valid, in_ready, out_valid, out_ready, acc_clr, acc_ovf;
  logic [3:0] in_data, out_data;
  logic [1:0] in_op, out_op;
  logic [2:0] count;
  logic [7:0] acc;
  int n_chk = 0, n_fail = 0;

  alu_result_buffer #(.DEPTH(4), .ACC_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_op(out_op), .count(count), .acc_clr(acc_clr), .acc(acc), .acc_ovf(acc_ovf));

  always #5 clk = ~clk;

  typedef struct {
    logic r, iv; logic [3:0] d; logic [1:0] op; logic ordy, clr;
    int cnt; logic ov; logic cd; int od; int oop; logic ir; int ac; logic of;
  } vec_t;

  vec_t tv[16];

  function automatic vec_t v(logic r, logic iv, int d, int op, logic ordy, logic clr,
                             int cnt, logic ov, logic cd, int od, int oop, logic ir, int ac, logic of);
    vec_t x;
    x.r = r; x.iv = iv; x.d = 4'(d); x.op = 2'(op); x.ordy = ordy; x.clr = clr;
    x.cnt = cnt; x.ov = ov; x.cd = cd; x.od = od; x.oop = oop; x.ir = ir; x.ac = ac; x.of = of;
    return x;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic iv, int d, int op, logic ordy, logic clr);
    @(negedge clk);
    rst = r; in_valid = iv; in_data = 4'(d); in_op = 2'(op); out_ready = ordy; acc_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int q[$];
    rst = 1; in_valid = 0; in_data = 0; in_op = 0; out_ready = 0; acc_clr = 0;
    //        r iv  d op or clr  cnt ov cd od oop ir  acc of
    tv[0]  = v(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,   0, 0);
    tv[1]  = v(0, 1, 5, 2, 0, 0,  1, 1, 1, 5, 2, 1,   5, 0);
    tv[2]  = v(0, 1, 9, 3, 0, 0,  2, 1, 1, 5, 2, 1,  14, 0);
    tv[3]  = v(0, 1,14, 1, 0, 0,  3, 1, 1, 5, 2, 1,  14, 0);
    tv[4]  = v(0, 1, 3, 0, 0, 0,  4, 1, 1, 5, 2, 0,  14, 0);
    tv[5]  = v(0, 1, 7, 2, 0, 0,  4, 1, 1, 5, 2, 0,  14, 0);
    tv[6]  = v(0, 1, 7, 2, 1, 0,  3, 1, 1, 9, 3, 1,  14, 0);
    tv[7]  = v(0, 0, 0, 0, 1, 0,  2, 1, 1,14, 1, 1,  14, 0);
    tv[8]  = v(0, 0, 0, 0, 1, 0,  1, 1, 1, 3, 0, 1,  14, 0);
    tv[9]  = v(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1,  14, 0);
    tv[10] = v(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1,  14, 0);
    tv[11] = v(0, 1, 7, 2, 0, 1,  1, 1, 1, 7, 2, 1,   0, 0);
    tv[12] = v(0, 1, 2, 2, 0, 0,  2, 1, 1, 7, 2, 1,   2, 0);
    tv[13] = v(0, 1, 4, 3, 0, 0,  3, 1, 1, 7, 2, 1,   6, 0);
    tv[14] = v(1, 1, 9, 2, 1, 0,  0, 0, 1, 0, 0, 0,   0, 0);
    tv[15] = v(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1,   0, 0);
    for (int i = 0; i < 16; i++) begin
      drive(tv[i].r, tv[i].iv, tv[i].d, tv[i].op, tv[i].ordy, tv[i].clr);
      chk($sformatf("v%0d count", i), count, tv[i].cnt);
      chk($sformatf("v%0d out_valid", i), out_valid, tv[i].ov);
      if (tv[i].cd) begin
        chk($sformatf("v%0d out_data", i), out_data, tv[i].od);
        chk($sformatf("v%0d out_op", i), out_op, tv[i].oop);
      end
      chk($sformatf("v%0d in_ready", i), in_ready, tv[i].ir);
      chk($sformatf("v%0d acc", i), acc, tv[i].ac);
      chk($sformatf("v%0d acc_ovf", i), acc_ovf, tv[i].of);
    end
    // simultaneous push/pop at count=2 across pointer wrap
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 2, 1, 0, 0);
    q.push_back(1); q.push_back(2);
    for (int k = 3; k < 13; k++) begin
      chk("wrap head", out_data, q[0]);
      drive(0, 1, k, 0, 1, 0);
      void'(q.pop_front());
      q.push_back(k);
      chk("wrap count", count, 2);
    end
    chk("wrap final head", out_data, q[0]);
    // accumulator overflow with MUL 9, draining as we go
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      drive(0, 1, 9, 3, 1, 0);
      if (k == 28) begin chk("acc28", acc, 252); chk("ovf28", acc_ovf, 0); end
      if (k == 29) begin chk("acc29", acc, 5);   chk("ovf29", acc_ovf, 1); end
      if (k == 30) begin chk("acc30", acc, 14);  chk("ovf30", acc_ovf, 1); end
    end
    drive(0, 0, 0, 0, 1, 1);
    chk("clr acc", acc, 0);
    chk("clr ovf", acc_ovf, 0);
    chk("clr count", count, 0);
    drive(0, 1, 3, 0, 0, 0);
    chk("logic op acc", acc, 0);
    chk("logic op count", count, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
